// File: rtl/onchip_ram_arbiter.sv
// Two-master arbiter for the single-port on-chip RAM.
// Masters m0 (Nios II data) and m1 (game logic) share the RAM with
// round-robin arbitration, optional lock hold, in-order read return and a
// RUN/DRAIN/HALT quiesce sequence driven by ram_reset_req.
module onchip_ram_arbiter #(
    parameter int AW = 2,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic [AW-1:0]     m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DW/8-1:0]   m0_byteenable,
    input  logic [DW-1:0]     m0_writedata,
    input  logic              m0_lock,
    output logic              m0_waitrequest,
    output logic [DW-1:0]     m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [AW-1:0]     m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DW/8-1:0]   m1_byteenable,
    input  logic [DW-1:0]     m1_writedata,
    input  logic              m1_lock,
    output logic              m1_waitrequest,
    output logic [DW-1:0]     m1_readdata,
    output logic              m1_readdatavalid,

    output logic [AW-1:0]     ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [DW/8-1:0]   ram_byteenable,
    output logic [DW-1:0]     ram_writedata,
    output logic              ram_clken,
    input  logic [DW-1:0]     ram_readdata,
    input  logic              ram_reset_req
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   lock_valid_q, lock_valid_d;
    logic   lock_owner_q, lock_owner_d;
    logic   rd_pend_q,    rd_pend_d;
    logic   rd_id_q,      rd_id_d;

    logic   req0, req1;
    logic   grant_en;
    logic   gnt0, gnt1;
    logic   accept;
    logic   win_id;
    logic   win_read;
    logic   win_lock;

    // Grant decision: single requester wins, else lock owner, else the master not granted last
    always_comb begin
        req0     = m0_read | m0_write;
        req1     = m1_read | m1_write;
        grant_en = (state_q == ST_RUN) && !ram_reset_req;
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        if (grant_en) begin
            if (req0 && !req1) begin
                gnt0 = 1'b1;
            end else if (req1 && !req0) begin
                gnt1 = 1'b1;
            end else if (req0 && req1) begin
                if (lock_valid_q) begin
                    gnt0 = ~lock_owner_q;
                    gnt1 =  lock_owner_q;
                end else begin
                    gnt0 =  last_grant_q;
                    gnt1 = ~last_grant_q;
                end
            end
        end
    end

    // Route the winning master's command onto the RAM port; idle cycles drive a quiet bus
    always_comb begin
        accept         = gnt0 | gnt1;
        win_id         = gnt1;
        win_read       = 1'b0;
        win_lock       = 1'b0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_address    = '0;
        ram_byteenable = '0;
        ram_writedata  = '0;
        if (gnt0) begin
            ram_chipselect = 1'b1;
            ram_write      = m0_write;
            ram_address    = m0_address;
            ram_byteenable = m0_byteenable;
            ram_writedata  = m0_writedata;
            win_read       = m0_read & ~m0_write;
            win_lock       = m0_lock;
        end else if (gnt1) begin
            ram_chipselect = 1'b1;
            ram_write      = m1_write;
            ram_address    = m1_address;
            ram_byteenable = m1_byteenable;
            ram_writedata  = m1_writedata;
            win_read       = m1_read & ~m1_write;
            win_lock       = m1_lock;
        end
    end

    assign m0_waitrequest   = ~gnt0;
    assign m1_waitrequest   = ~gnt1;
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m0_readdatavalid = rd_pend_q & ~rd_id_q;
    assign m1_readdatavalid = rd_pend_q &  rd_id_q;
    assign ram_clken        = (state_q != ST_HALT);

    // Next-state: quiesce sequencing, lock bookkeeping, round-robin history, read tracking
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        lock_valid_d = lock_valid_q;
        lock_owner_d = lock_owner_q;
        rd_pend_d    = accept & win_read;
        rd_id_d      = accept ? win_id : rd_id_q;

        if (accept) begin
            last_grant_d = win_id;
            if (win_lock) begin
                lock_owner_d = win_id;
                lock_valid_d = 1'b1;
            end else if (lock_valid_q && (lock_owner_q == win_id)) begin
                lock_valid_d = 1'b0;
            end
        end

        // No grant is possible in a cycle that leaves RUN, so the lock clear never races an accept
        case (state_q)
            ST_HALT: begin
                if (!ram_reset_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (ram_reset_req) begin
                    state_d      = ST_DRAIN;
                    lock_valid_d = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (!rd_pend_q) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    // State registers; asynchronous reset drops any outstanding read return
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HALT;
            last_grant_q <= 1'b1;
            lock_valid_q <= 1'b0;
            lock_owner_q <= 1'b0;
            rd_pend_q    <= 1'b0;
            rd_id_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            lock_valid_q <= lock_valid_d;
            lock_owner_q <= lock_owner_d;
            rd_pend_q    <= rd_pend_d;
            rd_id_q      <= rd_id_d;
        end
    end

endmodule

// File: tb/tb_onchip_ram_arbiter.sv
// Testbench for onchip_ram_arbiter: table-driven arbitration vectors,
// directed multi-cycle sequences and randomized traffic checked against
// a transaction-level model of the arbiter and RAM.
module tb_onchip_ram_arbiter;

    logic        clk;
    logic        reset_n;
    logic [1:0]  m0_address, m1_address;
    logic        m0_read, m0_write, m0_lock;
    logic        m1_read, m1_write, m1_lock;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [1:0]  ram_address;
    logic        ram_chipselect, ram_write, ram_clken;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata;
    logic [31:0] ram_q;
    logic        ram_reset_req;

    onchip_ram_arbiter #(.AW(2), .DW(32)) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .m0_address       (m0_address),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_byteenable    (m0_byteenable),
        .m0_writedata     (m0_writedata),
        .m0_lock          (m0_lock),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_byteenable    (m1_byteenable),
        .m1_writedata     (m1_writedata),
        .m1_lock          (m1_lock),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .ram_address      (ram_address),
        .ram_chipselect   (ram_chipselect),
        .ram_write        (ram_write),
        .ram_byteenable   (ram_byteenable),
        .ram_writedata    (ram_writedata),
        .ram_clken        (ram_clken),
        .ram_readdata     (ram_q),
        .ram_reset_req    (ram_reset_req)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single-port RAM with one-cycle registered read and byte-lane writes
    logic [31:0] ram_mem [4];
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect) begin
            if (ram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
                end
            end
            ram_q <= ram_mem[ram_address];
        end
    end

    typedef struct {
        logic        r0, w0, l0;
        logic [1:0]  a0;
        logic [31:0] d0;
        logic [3:0]  b0;
        logic        r1, w1, l1;
        logic [1:0]  a1;
        logic [31:0] d1;
        logic [3:0]  b1;
        logic        rreq;
    } stim_t;

    typedef struct {
        stim_t s;
        logic  ew0, ew1;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] data;
    } pend_t;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: plain transaction-level view of the arbiter
    bit          m_halted, m_draining;
    int          m_last, m_owner;
    logic [31:0] m_mem [4];
    pend_t       m_pend [$];

    // Outputs sampled by the most recent step
    logic        cap_w0, cap_w1, cap_v0, cap_v1, cap_clken;
    logic [31:0] cap_rd0, cap_rd1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic stim_t idle_s();
        stim_t s;
        s = '{r0:0, w0:0, l0:0, a0:0, d0:0, b0:0, r1:0, w1:0, l1:0, a1:0, d1:0, b1:0, rreq:0};
        return s;
    endfunction

    function automatic stim_t m0_op(bit rd, bit wr, int a, logic [31:0] d, logic [3:0] be);
        stim_t s = idle_s();
        s.r0 = rd; s.w0 = wr; s.a0 = 2'(a); s.d0 = d; s.b0 = be;
        return s;
    endfunction

    function automatic stim_t m1_op(bit rd, bit wr, int a, logic [31:0] d, logic [3:0] be);
        stim_t s = idle_s();
        s.r1 = rd; s.w1 = wr; s.a1 = 2'(a); s.d1 = d; s.b1 = be;
        return s;
    endfunction

    function automatic vec_t row(bit r0, bit l0, bit r1, bit l1, bit ew0, bit ew1);
        vec_t v;
        v.s = idle_s();
        v.s.r0 = r0; v.s.a0 = 2'd0; v.s.l0 = l0;
        v.s.r1 = r1; v.s.a1 = 2'd1; v.s.l1 = l1;
        v.ew0 = ew0; v.ew1 = ew1;
        return v;
    endfunction

    task automatic model_reset();
        m_halted   = 1'b1;
        m_draining = 1'b0;
        m_last     = 1;
        m_owner    = -1;
        m_pend.delete();
    endtask

    // One clock cycle: entered and left at a falling edge
    task automatic step(input stim_t s);
        bit          q0, q1, can, had_pend, wr, rd, lk;
        int          win, a;
        logic [31:0] d;
        logic [3:0]  be;
        bit          ev0, ev1;
        logic [31:0] ed;

        m0_read = s.r0; m0_write = s.w0; m0_lock = s.l0; m0_address = s.a0;
        m0_writedata = s.d0; m0_byteenable = s.b0;
        m1_read = s.r1; m1_write = s.w1; m1_lock = s.l1; m1_address = s.a1;
        m1_writedata = s.d1; m1_byteenable = s.b1;
        ram_reset_req = s.rreq;
        #2;

        ev0 = 0; ev1 = 0; ed = '0;
        if (m_pend.size() > 0) begin
            ev0 = (m_pend[0].id == 0);
            ev1 = (m_pend[0].id == 1);
            ed  = m_pend[0].data;
        end
        chk("valid0", m0_readdatavalid, ev0);
        chk("valid1", m1_readdatavalid, ev1);
        if (ev0) chk("rdata0", m0_readdata, ed);
        if (ev1) chk("rdata1", m1_readdata, ed);

        q0  = s.r0 | s.w0;
        q1  = s.r1 | s.w1;
        can = !m_halted && !m_draining && !s.rreq;
        win = -1;
        if (can) begin
            if (q0 && q1) win = (m_owner >= 0) ? m_owner : 1 - m_last;
            else if (q0)  win = 0;
            else if (q1)  win = 1;
        end
        if (q0) chk("wait0", m0_waitrequest, win != 0);
        if (q1) chk("wait1", m1_waitrequest, win != 1);
        chk("chipselect", ram_chipselect, win >= 0);
        chk("clken", ram_clken, !m_halted);

        wr = 0; rd = 0; lk = 0; a = 0; d = '0; be = '0;
        if (win == 0) begin wr = s.w0; rd = s.r0 & ~s.w0; lk = s.l0; a = s.a0; d = s.d0; be = s.b0; end
        if (win == 1) begin wr = s.w1; rd = s.r1 & ~s.w1; lk = s.l1; a = s.a1; d = s.d1; be = s.b1; end
        chk("ram_write", ram_write, wr);
        chk("ram_be", ram_byteenable, (win >= 0) ? be : 4'h0);
        if (win >= 0) begin
            chk("ram_addr", ram_address, a);
            if (wr) chk("ram_wdata", ram_writedata, d);
        end

        cap_w0 = m0_waitrequest; cap_w1 = m1_waitrequest;
        cap_v0 = m0_readdatavalid; cap_v1 = m1_readdatavalid;
        cap_rd0 = m0_readdata; cap_rd1 = m1_readdata; cap_clken = ram_clken;

        had_pend = (m_pend.size() > 0);
        if (had_pend) void'(m_pend.pop_front());
        if (win >= 0) begin
            if (rd) m_pend.push_back('{id: win, data: m_mem[a]});
            if (wr) begin
                for (int b = 0; b < 4; b++) if (be[b]) m_mem[a][8*b +: 8] = d[8*b +: 8];
            end
            m_last = win;
            if (lk) m_owner = win;
            else if (m_owner == win) m_owner = -1;
        end
        if (m_halted) begin
            if (!s.rreq) m_halted = 0;
        end else if (m_draining) begin
            if (!had_pend) begin m_draining = 0; m_halted = 1; end
        end else if (s.rreq) begin
            m_draining = 1;
            m_owner    = -1;
        end
        @(negedge clk);
    endtask

    vec_t  tab [12];
    stim_t s;
    int    rr_cnt;

    initial begin
        tab[0]  = row(1, 0, 1, 0, 0, 1);
        tab[1]  = row(1, 0, 1, 0, 1, 0);
        tab[2]  = row(1, 0, 1, 0, 0, 1);
        tab[3]  = row(1, 0, 1, 0, 1, 0);
        tab[4]  = row(1, 0, 1, 1, 0, 1);
        tab[5]  = row(1, 0, 1, 1, 1, 0);
        tab[6]  = row(1, 0, 1, 1, 1, 0);
        tab[7]  = row(1, 0, 1, 1, 1, 0);
        tab[8]  = row(1, 0, 1, 0, 1, 0);
        tab[9]  = row(1, 0, 1, 0, 0, 1);
        tab[10] = row(0, 0, 1, 0, 1, 0);
        tab[11] = row(1, 0, 1, 0, 0, 1);

        reset_n = 1'b0;
        s = idle_s();
        m0_read = 0; m0_write = 0; m0_lock = 0; m0_address = 0; m0_writedata = 0; m0_byteenable = 0;
        m1_read = 0; m1_write = 0; m1_lock = 0; m1_address = 0; m1_writedata = 0; m1_byteenable = 0;
        ram_reset_req = 0;
        for (int i = 0; i < 4; i++) m_mem[i] = '0;
        model_reset();

        // Reset values
        @(negedge clk);
        #2;
        chk("rst_wait0", m0_waitrequest, 1);
        chk("rst_wait1", m1_waitrequest, 1);
        chk("rst_clken", ram_clken, 0);
        chk("rst_cs", ram_chipselect, 0);
        chk("rst_valid0", m0_readdatavalid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(idle_s());

        // Seed every RAM word so later reads are defined
        for (int i = 0; i < 4; i++) step(m0_op(0, 1, i, 32'h0101_0101 * (i + 1), 4'hF));

        // Write then read back through m0
        step(m0_op(0, 1, 2, 32'hDEAD_BEEF, 4'hF));
        chk("wr_accept", cap_w0, 0);
        step(m0_op(1, 0, 2, 0, 0));
        step(idle_s());
        chk("rd_valid", cap_v0, 1);
        chk("rd_data", cap_rd0, 32'hDEAD_BEEF);

        // Partial byte-lane write
        step(m1_op(0, 1, 3, 32'hAAAA_AAAA, 4'hF));
        step(m1_op(0, 1, 3, 32'h1234_5678, 4'h3));
        step(m1_op(1, 0, 3, 0, 0));
        step(idle_s());
        chk("be_valid", cap_v1, 1);
        chk("be_data", cap_rd1, 32'hAAAA_5678);

        // Read and write together behave as a write
        step(m0_op(1, 1, 1, 32'h0BAD_F00D, 4'hF));
        step(idle_s());
        chk("rw_novalid0", cap_v0, 0);
        chk("rw_novalid1", cap_v1, 0);
        step(m0_op(1, 0, 1, 0, 0));
        step(idle_s());
        chk("rw_data", cap_rd0, 32'h0BAD_F00D);

        // Asynchronous reset while a read is outstanding
        m0_read = 1; m0_address = 2'd0;
        @(posedge clk);
        #1 reset_n = 1'b0;
        m0_read = 0;
        #1;
        chk("arst_valid0", m0_readdatavalid, 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("arst_hold_valid0", m0_readdatavalid, 0);
        end
        model_reset();
        reset_n = 1'b1;
        step(idle_s());
        chk("arst_after_valid0", cap_v0, 0);

        // Arbitration vectors: alternation, lock hold, unlock
        for (int i = 0; i < 12; i++) begin
            step(tab[i].s);
            if (tab[i].s.r0) chk($sformatf("tab%0d_wait0", i), cap_w0, tab[i].ew0);
            if (tab[i].s.r1) chk($sformatf("tab%0d_wait1", i), cap_w1, tab[i].ew1);
        end
        step(idle_s());

        // Drain: outstanding read still delivered, then halt and resume
        step(m0_op(1, 0, 2, 0, 0));
        s = m0_op(1, 0, 2, 0, 0); s.rreq = 1;
        step(s);
        chk("drain_valid", cap_v0, 1);
        chk("drain_data", cap_rd0, 32'hDEAD_BEEF);
        chk("drain_block", cap_w0, 1);
        step(s);
        step(s);
        chk("halt_clken", cap_clken, 0);
        chk("halt_wait", cap_w0, 1);
        s.rreq = 0;
        step(s);
        chk("resume_wait_halt", cap_w0, 1);
        step(s);
        chk("resume_grant", cap_w0, 0);
        step(idle_s());

        // Randomized traffic against the model
        rr_cnt = 0;
        for (int i = 0; i < 600; i++) begin
            s = idle_s();
            s.r0 = ($urandom_range(0, 2) != 0);
            s.w0 = ($urandom_range(0, 3) == 0);
            s.l0 = ($urandom_range(0, 5) == 0);
            s.a0 = 2'($urandom_range(0, 3));
            s.d0 = $urandom;
            s.b0 = 4'($urandom_range(0, 15));
            s.r1 = ($urandom_range(0, 2) != 0);
            s.w1 = ($urandom_range(0, 3) == 0);
            s.l1 = ($urandom_range(0, 5) == 0);
            s.a1 = 2'($urandom_range(0, 3));
            s.d1 = $urandom;
            s.b1 = 4'($urandom_range(0, 15));
            if (rr_cnt > 0) begin
                rr_cnt--;
                s.rreq = 1;
            end else if ($urandom_range(0, 39) == 0) begin
                rr_cnt = $urandom_range(0, 4);
                s.rreq = 1;
            end
            step(s);
        end
        step(idle_s());
        step(idle_s());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
